id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid in 1, ID holds a real instruction; stall in 1, hold EX contents; flush in 1, load a bubble.
REQ-003 SHALL have ID inputs: id_rs_data/id_rt_data in 32; id_imm in 16; id_shamt, id_rs, id_rt, id_dst in 5 each.
REQ-004 SHALL have ID control inputs (1 bit unless stated): id_alu_op in 4; id_src_imm; id_imm_zext; id_shift; id_reg_write; id_mem_read; id_mem_write.
REQ-005 SHALL have forwarding inputs: exm_reg_write in 1, exm_dst in 5, exm_result in 32, mwb_reg_write in 1, mwb_dst in 5, mwb_result in 32.
REQ-006 SHALL have outputs: ex_valid 1; ex_inputA, ex_inputB, ex_store_data 32 each; ex_operation 4, feeding the ALU.
REQ-007 SHALL have outputs: ex_dst 5; ex_reg_write, ex_mem_read, ex_mem_write 1 each; hazard 1, ID must stall.

Function
REQ-008 SHALL, per clk edge, apply first match: flush or !in_valid -> bubble; stall -> hold; else load all ID fields.
REQ-009 SHALL build a bubble as: valid=0, reg_write/mem_read/mem_write=0, operation 4'b1111 (ALU result 0), all data fields 0.
REQ-010 SHALL let flush override stall in the same cycle.
REQ-011 SHALL extend imm at load: zero-extend if id_imm_zext=1, else sign-extend to 32 bits.
REQ-012 SHALL forward srcA (registered rs) and srcB (registered rt), each combinationally, in priority order: exm hit, then mwb hit, then registered data.
REQ-013 SHALL define a hit as reg_write=1, dst equal to the source number, and dst not 0; register 0 SHALL never be forwarded.
REQ-014 SHALL drive ex_inputA = {27'b0, shamt} when shift=1, else forwarded srcA.
REQ-015 SHALL drive ex_inputB = extended imm when src_imm=1, else forwarded srcB.
REQ-016 SHALL drive ex_store_data = forwarded srcB regardless of src_imm.
REQ-017 SHALL, during stall with a forwarding hit, overwrite the held rs/rt data with the forwarded value at the clock edge, so the value survives once the producer retires.
REQ-018 SHALL assert hazard combinationally when ex_valid & ex_mem_read & ex_dst!=0 & (ex_dst==id_rs | ex_dst==id_rt); in_valid is not a term.
REQ-019 SHALL give zero-cycle latency from registered state to outputs: a field loaded at edge N appears at ex_* after edge N.

Reset
REQ-020 SHALL, while rst_n=0, hold the bubble state of REQ-009 immediately, without waiting for clk.
REQ-021 SHALL make the next edge after rst_n deasserts a normal REQ-008 update.
REQ-022 SHALL, on reset mid-stall, discard the held instruction.

Configuration
REQ-023 SHALL compile the forwarding muxes and stall capture (REQ-012..017) in only when macro ID_EX_FORWARD_EN is defined.
REQ-024 SHALL, without ID_EX_FORWARD_EN, use registered rs/rt data directly.
REQ-025 SHALL, without ID_EX_FORWARD_EN, also assert hazard when an ID source (not 0) matches ex_dst with ex_valid & ex_reg_write, or matches exm_dst with exm_reg_write.
REQ-026 SHALL, in both builds, rely on a write-first register file for mwb results.

Verification
REQ-027 SHALL cover: load addi rs=$1 data 5, imm 16'hFFFF, zext=0, ALU_ADD -> inputA=5, inputB=32'hFFFFFFFF, operation=0000 next cycle.
REQ-028 SHALL cover: EX rs=$3, exm_dst=3 result 32'hAA, mwb_dst=3 result 32'hBB, both writing -> inputA=32'hAA; with exm_dst=0 -> 32'hBB.
REQ-029 SHALL cover: EX holds lw to $4; ID id_rt=4 -> hazard=1; stall 1 cycle, then ID id_rt=5 -> hazard=0; EX unchanged through the stall.
REQ-030 SHALL cover: stall=1, flush=1 together -> ex_valid=0, ex_reg_write=0, ex_operation=4'b1111 after the edge.
REQ-031 SHALL cover: stall with mwb hit on rt = 32'h1234, mwb cleared next cycle, stall released -> ex_store_data still 32'h1234.
REQ-032 SHALL cover: rst_n low mid-cycle with a valid instruction held -> ex_valid=0 at once, without a clock edge.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion, stall hold and load-use hazard detection.
// Define ID_EX_FORWARD_EN to build in EX-stage operand forwarding and forward capture on stall.
module id_ex_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dst,
    input  logic [3:0]  id_alu_op,
    input  logic        id_src_imm,
    input  logic        id_imm_zext,
    input  logic        id_shift,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_dst,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_dst,
    input  logic [31:0] mwb_result,
    output logic        ex_valid,
    output logic [31:0] ex_inputA,
    output logic [31:0] ex_inputB,
    output logic [31:0] ex_store_data,
    output logic [3:0]  ex_operation,
    output logic [4:0]  ex_dst,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        hazard
);

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  shamt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [3:0]  alu_op;
        logic        src_imm;
        logic        shift;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_stage_t;

    ex_stage_t   stage_q;
    ex_stage_t   stage_d;
    ex_stage_t   bubble;
    ex_stage_t   load;
    logic [31:0] src_a;
    logic [31:0] src_b;

    // ALU opcode 4'b1111 yields a zero result, so a bubble is harmless downstream.
    always_comb begin
        bubble        = '0;
        bubble.alu_op = 4'b1111;
    end

    always_comb begin
        load.valid     = 1'b1;
        load.rs_data   = id_rs_data;
        load.rt_data   = id_rt_data;
        load.imm_ext   = id_imm_zext ? {16'b0, id_imm} : {{16{id_imm[15]}}, id_imm};
        load.shamt     = id_shamt;
        load.rs        = id_rs;
        load.rt        = id_rt;
        load.dst       = id_dst;
        load.alu_op    = id_alu_op;
        load.src_imm   = id_src_imm;
        load.shift     = id_shift;
        load.reg_write = id_reg_write;
        load.mem_read  = id_mem_read;
        load.mem_write = id_mem_write;
    end

`ifdef ID_EX_FORWARD_EN
    logic exm_hit_a;
    logic exm_hit_b;
    logic mwb_hit_a;
    logic mwb_hit_b;

    assign exm_hit_a = exm_reg_write && (exm_dst != 5'd0) && (exm_dst == stage_q.rs);
    assign exm_hit_b = exm_reg_write && (exm_dst != 5'd0) && (exm_dst == stage_q.rt);
    assign mwb_hit_a = mwb_reg_write && (mwb_dst != 5'd0) && (mwb_dst == stage_q.rs);
    assign mwb_hit_b = mwb_reg_write && (mwb_dst != 5'd0) && (mwb_dst == stage_q.rt);

    // The younger producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        if (exm_hit_a) begin
            src_a = exm_result;
        end else if (mwb_hit_a) begin
            src_a = mwb_result;
        end else begin
            src_a = stage_q.rs_data;
        end
    end

    always_comb begin
        if (exm_hit_b) begin
            src_b = exm_result;
        end else if (mwb_hit_b) begin
            src_b = mwb_result;
        end else begin
            src_b = stage_q.rt_data;
        end
    end
`else
    logic unused_fwd;

    assign src_a      = stage_q.rs_data;
    assign src_b      = stage_q.rt_data;
    assign unused_fwd = ^{exm_result, mwb_reg_write, mwb_dst, mwb_result, stage_q.rs, stage_q.rt};
`endif

    always_comb begin
        stage_d = stage_q;
        if (flush || !in_valid) begin
            stage_d = bubble;
        end else if (stall) begin
`ifdef ID_EX_FORWARD_EN
            // Capture forwarded operands so they outlive the producer's retirement.
            stage_d.rs_data = src_a;
            stage_d.rt_data = src_b;
`endif
        end else begin
            stage_d = load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= bubble;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ex_valid      = stage_q.valid;
    assign ex_inputA     = stage_q.shift ? {27'b0, stage_q.shamt} : src_a;
    assign ex_inputB     = stage_q.src_imm ? stage_q.imm_ext : src_b;
    assign ex_store_data = src_b;
    assign ex_operation  = stage_q.alu_op;
    assign ex_dst        = stage_q.dst;
    assign ex_reg_write  = stage_q.reg_write;
    assign ex_mem_read   = stage_q.mem_read;
    assign ex_mem_write  = stage_q.mem_write;

    logic load_use;

    assign load_use = stage_q.valid && stage_q.mem_read && (stage_q.dst != 5'd0) &&
                      ((stage_q.dst == id_rs) || (stage_q.dst == id_rt));

`ifdef ID_EX_FORWARD_EN
    assign hazard = load_use;
`else
    // Without forwarding, any in-flight writer of an ID source must drain first.
    function automatic logic raw_conflict(input logic [4:0] src);
        logic ex_hit;
        logic exm_hit;
        ex_hit  = stage_q.valid && stage_q.reg_write && (stage_q.dst == src);
        exm_hit = exm_reg_write && (exm_dst == src);
        return (src != 5'd0) && (ex_hit || exm_hit);
    endfunction

    assign hazard = load_use || raw_conflict(id_rs) || raw_conflict(id_rt);
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: stimulus queues expected values, a negedge monitor checks them.
// Expectations follow ID_EX_FORWARD_EN when the bench is built with it defined.
module tb_id_ex_reg;

`ifdef ID_EX_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    localparam int SelValid = 0;
    localparam int SelA     = 1;
    localparam int SelB     = 2;
    localparam int SelStore = 3;
    localparam int SelOp    = 4;
    localparam int SelDst   = 5;
    localparam int SelRw    = 6;
    localparam int SelMr    = 7;
    localparam int SelMw    = 8;
    localparam int SelHaz   = 9;

    logic        clk;
    logic        rst_n;
    logic        in_valid, stall, flush;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_dst;
    logic [3:0]  id_alu_op;
    logic        id_src_imm, id_imm_zext, id_shift, id_reg_write, id_mem_read, id_mem_write;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_dst, mwb_dst;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid;
    logic [31:0] ex_inputA, ex_inputB, ex_store_data;
    logic [3:0]  ex_operation;
    logic [4:0]  ex_dst;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, hazard;

    id_ex_reg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .id_shamt      (id_shamt),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_dst        (id_dst),
        .id_alu_op     (id_alu_op),
        .id_src_imm    (id_src_imm),
        .id_imm_zext   (id_imm_zext),
        .id_shift      (id_shift),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .exm_reg_write (exm_reg_write),
        .exm_dst       (exm_dst),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_dst       (mwb_dst),
        .mwb_result    (mwb_result),
        .ex_valid      (ex_valid),
        .ex_inputA     (ex_inputA),
        .ex_inputB     (ex_inputB),
        .ex_store_data (ex_store_data),
        .ex_operation  (ex_operation),
        .ex_dst        (ex_dst),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .hazard        (hazard)
    );

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SelValid: return {31'b0, ex_valid};
            SelA:     return ex_inputA;
            SelB:     return ex_inputB;
            SelStore: return ex_store_data;
            SelOp:    return {28'b0, ex_operation};
            SelDst:   return {27'b0, ex_dst};
            SelRw:    return {31'b0, ex_reg_write};
            SelMr:    return {31'b0, ex_mem_read};
            SelMw:    return {31'b0, ex_mem_write};
            SelHaz:   return {31'b0, hazard};
            default:  return 'x;
        endcase
    endfunction

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            checks++;
            if (e.cyc != cyc || a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         e.name, a, e.exp, cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input int c, input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] dst, input logic [31:0] rsd,
                            input logic [31:0] rtd, input logic [15:0] imm, input bit zext,
                            input bit src_imm, input bit shift, input logic [4:0] shamt,
                            input logic [3:0] op, input bit rw, input bit mr, input bit mw);
        in_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_dst       = dst;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_imm       = imm;
        id_imm_zext  = zext;
        id_src_imm   = src_imm;
        id_shift     = shift;
        id_shamt     = shamt;
        id_alu_op    = op;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
    endtask

    task automatic set_fwd(input bit erw, input logic [4:0] ed, input logic [31:0] er,
                           input bit mrw, input logic [4:0] md, input logic [31:0] mr);
        exm_reg_write = erw;
        exm_dst       = ed;
        exm_result    = er;
        mwb_reg_write = mrw;
        mwb_dst       = md;
        mwb_result    = mr;
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);

        tick; c = cyc;
        push_exp(c, "reset_valid", SelValid, 32'd0);
        push_exp(c, "reset_op", SelOp, 32'hF);
        push_exp(c, "reset_rw", SelRw, 32'd0);
        push_exp(c, "reset_inputA", SelA, 32'd0);
        push_exp(c, "reset_hazard", SelHaz, 32'd0);
        tick; rst_n = 1'b1;

        // addi $2, $1(=5), -1
        tick; c = cyc;
        drive_id(1, 1, 2, 2, 32'd5, 32'd0, 16'hFFFF, 0, 1, 0, 0, 4'h0, 1, 0, 0);
        push_exp(c + 1, "addi_valid", SelValid, 32'd1);
        push_exp(c + 1, "addi_inputA", SelA, 32'd5);
        push_exp(c + 1, "addi_inputB_sext", SelB, 32'hFFFF_FFFF);
        push_exp(c + 1, "addi_op", SelOp, 32'h0);
        push_exp(c + 1, "addi_dst", SelDst, 32'd2);
        push_exp(c + 1, "addi_rw", SelRw, 32'd1);

        // ori with zero-extended 16'h8000
        tick; c = cyc;
        drive_id(1, 1, 3, 3, 32'd5, 32'd0, 16'h8000, 1, 1, 0, 0, 4'h3, 1, 0, 0);
        push_exp(c, "ori_hazard", SelHaz, 32'd0);
        push_exp(c + 1, "ori_inputB_zext", SelB, 32'h0000_8000);
        push_exp(c + 1, "ori_op", SelOp, 32'h3);

        // R-type: immediate must be ignored
        tick; c = cyc;
        drive_id(1, 6, 7, 8, 32'h11, 32'h22, 16'h8000, 0, 0, 0, 0, 4'h2, 1, 0, 0);
        push_exp(c + 1, "rtype_inputA", SelA, 32'h11);
        push_exp(c + 1, "rtype_inputB", SelB, 32'h22);
        push_exp(c + 1, "rtype_store", SelStore, 32'h22);

        // sll by 5
        tick; c = cyc;
        drive_id(1, 0, 7, 9, 32'd0, 32'h22, 16'h0, 0, 0, 1, 5'd5, 4'h4, 1, 0, 0);
        push_exp(c, "sll_id_hazard", SelHaz, 32'd0);
        push_exp(c + 1, "sll_inputA_shamt", SelA, 32'd5);
        push_exp(c + 1, "sll_inputB", SelB, 32'h22);

        // in_valid=0 loads a bubble; ID reads $9 which the EX sll writes
        tick; c = cyc;
        drive_id(0, 9, 0, 8, 32'h99, 32'h0, 16'h0, 0, 0, 0, 0, 4'h1, 1, 0, 0);
        push_exp(c, "raw_hazard_build", SelHaz, Fwd ? 32'd0 : 32'd1);
        push_exp(c + 1, "invalid_valid", SelValid, 32'd0);
        push_exp(c + 1, "invalid_op", SelOp, 32'hF);
        push_exp(c + 1, "invalid_rw", SelRw, 32'd0);
        push_exp(c + 1, "invalid_dst", SelDst, 32'd0);
        push_exp(c + 1, "invalid_inputA", SelA, 32'd0);

        // Forwarding priority on rs=$3
        tick;
        drive_id(1, 3, 0, 10, 32'h33, 32'd0, 16'h0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        tick; c = cyc;
        stall = 1'b1;
        set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB);
        push_exp(c, "fwd_exm_priority", SelA, Fwd ? 32'hAA : 32'h33);
        tick; c = cyc;
        exm_dst = 5'd0;
        push_exp(c, "fwd_mwb_only", SelA, Fwd ? 32'hBB : 32'h33);

        // $0 is never forwarded
        tick; c = cyc;
        stall = 1'b0;
        set_fwd(1, 0, 32'hDEAD, 0, 0, 0);
        drive_id(1, 0, 0, 11, 32'd0, 32'd0, 16'h0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        push_exp(c + 1, "r0_no_fwd_A", SelA, 32'd0);
        push_exp(c + 1, "r0_no_fwd_store", SelStore, 32'd0);

        // lw $4, 4($1)
        tick;
        drive_id(1, 1, 0, 4, 32'd100, 32'd0, 16'd4, 0, 1, 0, 0, 4'h0, 1, 1, 0);
        tick; c = cyc;
        set_fwd(0, 0, 0, 0, 0, 0);
        stall = 1'b1;
        drive_id(1, 2, 4, 5, 32'd7, 32'd8, 16'h0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        push_exp(c, "loaduse_hazard", SelHaz, 32'd1);
        push_exp(c, "lw_valid", SelValid, 32'd1);
        push_exp(c, "lw_dst", SelDst, 32'd4);
        push_exp(c, "lw_mem_read", SelMr, 32'd1);
        tick; c = cyc;
        stall = 1'b0;
        drive_id(1, 2, 5, 5, 32'd7, 32'd8, 16'h0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        push_exp(c, "no_hazard_rt5", SelHaz, 32'd0);
        push_exp(c, "stall_held_dst", SelDst, 32'd4);
        push_exp(c, "stall_held_mr", SelMr, 32'd1);
        push_exp(c, "stall_held_A", SelA, 32'd100);
        push_exp(c, "stall_held_B", SelB, 32'd4);

        // Flush overrides stall
        tick; c = cyc;
        stall = 1'b1;
        flush = 1'b1;
        push_exp(c, "preflush_valid", SelValid, 32'd1);
        push_exp(c + 1, "flush_valid", SelValid, 32'd0);
        push_exp(c + 1, "flush_rw", SelRw, 32'd0);
        push_exp(c + 1, "flush_op", SelOp, 32'hF);
        push_exp(c + 1, "flush_inputB", SelB, 32'd0);

        // sw with stale rt data, MEM/WB supplies $8 while stalled
        tick;
        stall = 1'b0;
        flush = 1'b0;
        drive_id(1, 1, 8, 0, 32'h10, 32'h999, 16'd8, 0, 1, 0, 0, 4'h0, 0, 0, 1);
        tick; c = cyc;
        stall = 1'b1;
        set_fwd(0, 0, 0, 1, 8, 32'h1234);
        push_exp(c, "sw_store_fwd", SelStore, Fwd ? 32'h1234 : 32'h999);
        push_exp(c, "sw_mem_write", SelMw, 32'd1);
        tick; c = cyc;
        stall = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        push_exp(c, "sw_store_captured", SelStore, Fwd ? 32'h1234 : 32'h999);
        push_exp(c, "sw_inputB_imm", SelB, 32'd8);

        // Asynchronous reset while a valid instruction is held
        tick;
        drive_id(1, 1, 0, 12, 32'h55, 32'd0, 16'h0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        tick; c = cyc;
        stall = 1'b1;
        push_exp(c, "held_valid", SelValid, 32'd1);
        push_exp(c, "held_inputA", SelA, 32'h55);
        tick; c = cyc;
        rst_n = 1'b0;
        push_exp(c, "async_rst_valid", SelValid, 32'd0);
        push_exp(c, "async_rst_op", SelOp, 32'hF);
        push_exp(c, "async_rst_dst", SelDst, 32'd0);
        push_exp(c, "async_rst_inputA", SelA, 32'd0);
        tick; c = cyc;
        rst_n = 1'b1;
        push_exp(c, "in_reset_valid", SelValid, 32'd0);
        tick; c = cyc;
        stall = 1'b0;
        push_exp(c, "post_rst_discard_valid", SelValid, 32'd0);
        push_exp(c, "post_rst_discard_dst", SelDst, 32'd0);
        tick; c = cyc;
        push_exp(c, "post_rst_load_valid", SelValid, 32'd1);
        push_exp(c, "post_rst_load_dst", SelDst, 32'd12);
        push_exp(c, "post_rst_load_A", SelA, 32'h55);

        @(negedge clk);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d checks still pending, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
